// File: rtl/fft_pkg.sv
// Shared definitions for the FFT stage address generators (read and write side):
// FSM state encodings, half-span derivation and an address bit-reversal helper.
package fft_pkg;

   // One-hot-ish state encoding shared by the read and write generators.
   typedef enum logic [2:0] {
      IDLE = 3'b001,
      WR_1 = 3'b010,
      WR_2 = 3'b011,
      DONE = 3'b100
   } fft_state_t;

   // Widest address the bit-reversal helper handles.
   localparam int ADDR_W_MAX = 32;

   // Butterfly half-span H = 2^(stage-1) for a radix-2 stage (stage counts from 1).
   function automatic int half_span(input int stage);
      return 1 << (stage - 1);
   endfunction

   // Reverse the low 'size' bits of addr; bits above 'size' come back as zero.
   function automatic logic [ADDR_W_MAX-1:0] bit_rev(input logic [ADDR_W_MAX-1:0] addr,
                                                     input int size);
      logic [ADDR_W_MAX-1:0] rev;
      rev = '0;
      for (int i = 0; i < ADDR_W_MAX; i++) begin
         if (i < size) begin
            rev[i] = addr[size-1-i];
         end
      end
      return rev;
   endfunction

endpackage

// File: rtl/fft_wr_addr_gen.sv
// Write-side address generator for one radix-2 FFT stage.
// Accepts butterfly results in the read side's pair order, registers each sample,
// issues the in-place write address into the ping-pong RAM with en_wr, and pulses
// stage_done once all N results are written.
// Optional build macro FFT_WR_BITREV_EN: on the final stage (stage_FFT == SIZE) the
// write address is bit-reversed so the output buffer lands in natural order.
module fft_wr_addr_gen
   import fft_pkg::*;
#(
   parameter int stage_FFT = 2,
   parameter int N         = 16,
   parameter int SIZE      = 4,
   parameter int DATA_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_stage,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_re,
   input  logic [DATA_W-1:0] in_im,
   output logic              en_wr,
   output logic [SIZE-1:0]   wr_ptr,
   output logic [DATA_W-1:0] wr_re,
   output logic [DATA_W-1:0] wr_im,
   output logic              busy,
   output logic              stage_done,
   output logic              drop_err
);

   // Half-span and derived counter constants, all truncated to the counter width.
   // For the final stage 2H equals N, so the group step wraps g back to 0.
   localparam int            H        = half_span(stage_FFT);
   localparam logic [SIZE-1:0] H_V      = SIZE'(H);
   localparam logic [SIZE-1:0] K_LAST_V = SIZE'(H - 1);
   localparam logic [SIZE-1:0] G_STEP_V = SIZE'(2 * H);
   localparam logic [SIZE-1:0] LAST_V   = SIZE'(N - 1);

   fft_state_t      state_reg;
   logic [SIZE-1:0] g_reg;      // base address of the current butterfly group
   logic [SIZE-1:0] k_reg;      // offset of the current pair inside the group

   logic [SIZE-1:0] addr_lo;    // first element of the pair
   logic [SIZE-1:0] addr_hi;    // second element of the pair, H above the first

   // In-place addresses of the current butterfly pair.
   assign addr_lo = g_reg + k_reg;
   assign addr_hi = addr_lo + H_V;

   // Final RAM address: optionally bit-reversed on the last stage only.
   function automatic logic [SIZE-1:0] map_addr(input logic [SIZE-1:0] a);
`ifdef FFT_WR_BITREV_EN
      if (stage_FFT == SIZE) begin
         return SIZE'(bit_rev(ADDR_W_MAX'(a), SIZE));
      end
      return a;
`else
      return a;
`endif
   endfunction

   // Stage FSM with group/pair counters and registered write port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         g_reg      <= '0;
         k_reg      <= '0;
         en_wr      <= 1'b0;
         wr_ptr     <= '0;
         wr_re      <= '0;
         wr_im      <= '0;
         busy       <= 1'b0;
         stage_done <= 1'b0;
         drop_err   <= 1'b0;
      end else begin
         // Strobes default low; address and data hold between writes.
         en_wr      <= 1'b0;
         stage_done <= 1'b0;

         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  drop_err <= 1'b1;
               end
               if (start_stage) begin
                  state_reg <= WR_1;
                  busy      <= 1'b1;
                  // A sample arriving alongside the arm pulse is still dropped.
                  drop_err  <= in_valid;
               end
            end

            WR_1: begin
               if (in_valid) begin
                  wr_ptr    <= map_addr(addr_lo);
                  en_wr     <= 1'b1;
                  wr_re     <= in_re;
                  wr_im     <= in_im;
                  state_reg <= WR_2;
               end
            end

            WR_2: begin
               if (in_valid) begin
                  wr_ptr <= map_addr(addr_hi);
                  en_wr  <= 1'b1;
                  wr_re  <= in_re;
                  wr_im  <= in_im;
                  if (k_reg == K_LAST_V) begin
                     k_reg <= '0;
                     g_reg <= g_reg + G_STEP_V;
                  end else begin
                     k_reg <= k_reg + 1'b1;
                  end
                  if (addr_hi == LAST_V) begin
                     state_reg <= DONE;
                  end else begin
                     state_reg <= WR_1;
                  end
               end
            end

            DONE: begin
               stage_done <= 1'b1;
               busy       <= 1'b0;
               g_reg      <= '0;
               k_reg      <= '0;
               state_reg  <= IDLE;
               if (in_valid) begin
                  drop_err <= 1'b1;
               end
            end

            default: begin
               state_reg <= IDLE;
               busy      <= 1'b0;
               g_reg     <= '0;
               k_reg     <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fft_wr_addr_gen.sv
// Self-checking bench for fft_wr_addr_gen. Three instances (stages 2, 3 and 4 of a
// 16-point FFT) share one stimulus stream; a transaction-level model predicts every
// output each cycle and literal tables pin the expected address orders.
module tb_fft_wr_addr_gen;

   localparam int NDUT = 3;
   localparam int NPT  = 16;

   logic        clk;
   logic        rst_n;
   logic        start_stage;
   logic        in_valid;
   logic [15:0] in_re;
   logic [15:0] in_im;

   logic        en_wr_w   [NDUT];
   logic [3:0]  wr_ptr_w  [NDUT];
   logic [15:0] wr_re_w   [NDUT];
   logic [15:0] wr_im_w   [NDUT];
   logic        busy_w    [NDUT];
   logic        done_w    [NDUT];
   logic        drop_w    [NDUT];

   int tests = 0;
   int fails = 0;

   // Model state per instance.
   int          m_phase   [NDUT];   // 0 idle, 1 accepting samples, 2 finishing
   int          m_cnt     [NDUT];
   logic        e_en      [NDUT];
   logic [3:0]  e_ptr     [NDUT];
   logic [15:0] e_re      [NDUT];
   logic [15:0] e_im      [NDUT];
   logic        e_busy    [NDUT];
   logic        e_done    [NDUT];
   logic        e_drop    [NDUT];

   // Observed write addresses and stage_done pulses.
   logic [3:0]  cap       [NDUT][NPT];
   int          cap_n     [NDUT];
   int          done_cnt  [NDUT];

   for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
      fft_wr_addr_gen #(
         .stage_FFT(gi + 2),
         .N(NPT),
         .SIZE(4),
         .DATA_W(16)
      ) u_dut (
         .clk(clk),
         .rst_n(rst_n),
         .start_stage(start_stage),
         .in_valid(in_valid),
         .in_re(in_re),
         .in_im(in_im),
         .en_wr(en_wr_w[gi]),
         .wr_ptr(wr_ptr_w[gi]),
         .wr_re(wr_re_w[gi]),
         .wr_im(wr_im_w[gi]),
         .busy(busy_w[gi]),
         .stage_done(done_w[gi]),
         .drop_err(drop_w[gi])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Address of the idx-th result of a stage: results come in pairs (a, a+H),
   // pairs walk k = 0..H-1 inside a group, groups are 2H apart.
   function automatic logic [3:0] exp_addr(input int stage, input int idx);
      int h, pair, a, r;
      h    = 1 << (stage - 1);
      pair = idx / 2;
      a    = (pair / h) * 2 * h + (pair % h) + (idx % 2) * h;
`ifdef FFT_WR_BITREV_EN
      if (stage == 4) begin
         r = 0;
         for (int b = 0; b < 4; b++) r = r * 2 + ((a >> b) & 1);
         a = r;
      end
`endif
      r = a;
      return r[3:0];
   endfunction

   // Model: react to the inputs sampled at each rising edge.
   initial begin
      for (int d = 0; d < NDUT; d++) begin
         m_phase[d] = 0; m_cnt[d] = 0; e_en[d] = 0; e_ptr[d] = 0; e_re[d] = 0;
         e_im[d] = 0; e_busy[d] = 0; e_done[d] = 0; e_drop[d] = 0;
      end
      forever begin
         @(posedge clk);
         for (int d = 0; d < NDUT; d++) begin
            if (!rst_n) begin
               m_phase[d] = 0; m_cnt[d] = 0; e_en[d] = 0; e_ptr[d] = 0; e_re[d] = 0;
               e_im[d] = 0; e_busy[d] = 0; e_done[d] = 0; e_drop[d] = 0;
            end else begin
               e_en[d]   = 1'b0;
               e_done[d] = 1'b0;
               if (m_phase[d] == 1) begin
                  if (in_valid) begin
                     e_en[d]  = 1'b1;
                     e_ptr[d] = exp_addr(d + 2, m_cnt[d]);
                     e_re[d]  = in_re;
                     e_im[d]  = in_im;
                     m_cnt[d]++;
                     if (m_cnt[d] == NPT) m_phase[d] = 2;
                  end
               end else if (m_phase[d] == 2) begin
                  e_done[d] = 1'b1;
                  e_busy[d] = 1'b0;
                  m_phase[d] = 0;
                  m_cnt[d] = 0;
                  if (in_valid) e_drop[d] = 1'b1;
               end else begin
                  if (in_valid) e_drop[d] = 1'b1;
                  if (start_stage) begin
                     m_phase[d] = 1;
                     e_busy[d]  = 1'b1;
                     e_drop[d]  = in_valid;
                  end
               end
            end
         end
      end
   end

   // Compare every output of every instance on each falling edge.
   initial begin
      for (int d = 0; d < NDUT; d++) begin
         cap_n[d] = 0; done_cnt[d] = 0;
      end
      forever begin
         @(negedge clk);
         for (int d = 0; d < NDUT; d++) begin
            if (rst_n) begin
               check($sformatf("d%0d en_wr", d), 32'(en_wr_w[d]), 32'(e_en[d]));
               check($sformatf("d%0d wr_ptr", d), 32'(wr_ptr_w[d]), 32'(e_ptr[d]));
               check($sformatf("d%0d wr_re", d), 32'(wr_re_w[d]), 32'(e_re[d]));
               check($sformatf("d%0d wr_im", d), 32'(wr_im_w[d]), 32'(e_im[d]));
               check($sformatf("d%0d busy", d), 32'(busy_w[d]), 32'(e_busy[d]));
               check($sformatf("d%0d stage_done", d), 32'(done_w[d]), 32'(e_done[d]));
               check($sformatf("d%0d drop_err", d), 32'(drop_w[d]), 32'(e_drop[d]));
               if (en_wr_w[d] && cap_n[d] < NPT) begin
                  cap[d][cap_n[d]] = wr_ptr_w[d];
                  cap_n[d]++;
               end
               if (done_w[d]) done_cnt[d]++;
            end else begin
               check($sformatf("d%0d outputs in reset", d),
                     {en_wr_w[d], wr_ptr_w[d], busy_w[d], done_w[d], drop_w[d]}, 32'd0);
               check($sformatf("d%0d data in reset", d), {wr_re_w[d], wr_im_w[d]}, 32'd0);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_cap();
      for (int d = 0; d < NDUT; d++) begin
         cap_n[d] = 0; done_cnt[d] = 0;
      end
   endtask

   task automatic pulse_start();
      start_stage = 1'b1;
      tick();
      start_stage = 1'b0;
   endtask

   // Feed n samples; optional 0-3 idle cycles before each; optional start pulse
   // alongside sample 5 (must be ignored while busy).
   task automatic feed(input int n, input bit gaps, input bit mid_start);
      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
         end
         in_valid    = 1'b1;
         in_re       = 16'($urandom);
         in_im       = 16'($urandom);
         start_stage = mid_start && (i == 5);
         $display("[TB] sample %0d re=%04h im=%04h", i, in_re, in_im);
         tick();
      end
      in_valid    = 1'b0;
      start_stage = 1'b0;
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      while (!done_w[0] && k < 10) begin
         tick();
         k++;
      end
      check("stage_done within bound", 32'(done_w[0]), 32'd1);
      repeat (2) tick();
   endtask

   logic [3:0] lit2 [NPT];
   logic [3:0] lit3 [NPT];
   logic [3:0] lit4 [4];

   initial begin
      lit2 = '{0, 2, 1, 3, 4, 6, 5, 7, 8, 10, 9, 11, 12, 14, 13, 15};
      lit3 = '{0, 4, 1, 5, 2, 6, 3, 7, 8, 12, 9, 13, 10, 14, 11, 15};
`ifdef FFT_WR_BITREV_EN
      lit4 = '{0, 1, 8, 9};
`else
      lit4 = '{0, 8, 1, 9};
`endif
      rst_n = 1'b0; start_stage = 1'b0; in_valid = 1'b0; in_re = '0; in_im = '0;
      repeat (3) tick();
      check("reset en_wr", 32'(en_wr_w[0]), 32'd0);
      check("reset busy", 32'(busy_w[0]), 32'd0);
      rst_n = 1'b1;
      tick();

      // Back-to-back stage, with an ignored start pulse mid-stage.
      $display("[TB] stage: back-to-back");
      clear_cap();
      pulse_start();
      feed(NPT, 1'b0, 1'b1);
      wait_done();
      check("stage2 write count", 32'(cap_n[0]), 32'd16);
      for (int i = 0; i < NPT; i++) begin
         check($sformatf("stage2 addr[%0d]", i), 32'(cap[0][i]), 32'(lit2[i]));
         check($sformatf("stage3 addr[%0d]", i), 32'(cap[1][i]), 32'(lit3[i]));
      end
      for (int i = 0; i < 4; i++)
         check($sformatf("stage4 addr[%0d]", i), 32'(cap[2][i]), 32'(lit4[i]));
      check("stage_done pulses", 32'(done_cnt[0]), 32'd1);

      // Same stage with random gaps between samples.
      $display("[TB] stage: gapped input");
      clear_cap();
      pulse_start();
      feed(NPT, 1'b1, 1'b0);
      wait_done();
      for (int i = 0; i < NPT; i++)
         check($sformatf("gapped stage2 addr[%0d]", i), 32'(cap[0][i]), 32'(lit2[i]));
      check("gapped stage_done pulses", 32'(done_cnt[0]), 32'd1);

      // Sample while idle is dropped and flagged; arming clears the flag.
      $display("[TB] drop while idle");
      in_valid = 1'b1; in_re = 16'h1234; in_im = 16'h0;
      tick();
      in_valid = 1'b0;
      check("idle drop en_wr", 32'(en_wr_w[0]), 32'd0);
      check("idle drop_err set", 32'(drop_w[0]), 32'd1);
      check("idle drop wr_re untouched", 32'(wr_re_w[0] == 16'h1234), 32'd0);
      pulse_start();
      check("drop_err cleared by start", 32'(drop_w[0]), 32'd0);
      feed(NPT, 1'b0, 1'b0);
      wait_done();

      // Reset after 7 writes abandons the stage.
      $display("[TB] reset mid-stage");
      clear_cap();
      pulse_start();
      feed(7, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      check("mid reset en_wr", 32'(en_wr_w[0]), 32'd0);
      check("mid reset busy", 32'(busy_w[0]), 32'd0);
      check("mid reset wr_ptr", 32'(wr_ptr_w[1]), 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (3) tick();
      check("no stage_done after reset", 32'(done_cnt[0]), 32'd0);
      clear_cap();
      pulse_start();
      feed(NPT, 1'b0, 1'b0);
      wait_done();
      check("restart first wr_ptr", 32'(cap[0][0]), 32'd0);
      for (int i = 0; i < 4; i++)
         check($sformatf("restart stage4 addr[%0d]", i), 32'(cap[2][i]), 32'(lit4[i]));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
